// File: rtl/uart_cfg_cmd_rx.sv
// 8N1 UART receiver plus 7-byte command parser (A5|ADDR|D3..D0|CSUM) that writes
// the radar configuration registers feeding the VCO compensation block.
//
// state   | meaning
// R_IDLE  | line idle, waiting for a falling edge
// R_START | half-bit wait, confirm start bit still low
// R_DATA  | sampling 8 data bits, LSB first
// R_STOP  | sampling the stop bit
// P_HUNT  | waiting for the 0xA5 sync byte
// P_ADDR  | expecting address byte
// P_D3-D0 | expecting data bytes, MSB first
// P_CSUM  | expecting checksum, commit or drop on arrival
module uart_cfg_cmd_rx #(
  parameter int          SYS_CLK_FREQ_MHZ = 50,
  parameter int          BAUD_RATE        = 921600,
  parameter int          TIMEOUT_CYC      = 50000,
  parameter logic        RST_MODE         = 1'b0,
  parameter logic [31:0] RST_TRIG_PSC     = 32'd5000000,
  parameter logic [4:0]  RST_CHIRP_NUM    = 5'd16,
  parameter logic [15:0] RST_CHIRP_PSC    = 16'd1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rs232_rx_i,
  output logic        mode_sel_o,
  output logic [31:0] trigger_freq_psc_o,
  output logic [4:0]  chirp_num_o,
  output logic [15:0] chirp_freq_psc_o,
  output logic        cfg_update_o,
  output logic [1:0]  cfg_addr_o,
  output logic        cmd_err_o
);

  localparam int BIT_CYC = (SYS_CLK_FREQ_MHZ * 1000000 + BAUD_RATE / 2) / BAUD_RATE;
  localparam int BT_W    = $clog2(BIT_CYC + 1);
  localparam int TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [BT_W-1:0] BIT_LOAD  = BT_W'(BIT_CYC - 1);
  localparam logic [BT_W-1:0] HALF_LOAD = BT_W'(BIT_CYC / 2 - 1);
  localparam logic [TO_W-1:0] TO_LOAD   = TO_W'(TIMEOUT_CYC - 1);

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_START = 2'd1;
  localparam logic [1:0] R_DATA  = 2'd2;
  localparam logic [1:0] R_STOP  = 2'd3;

  localparam logic [2:0] P_HUNT = 3'd0;
  localparam logic [2:0] P_ADDR = 3'd1;
  localparam logic [2:0] P_D3   = 3'd2;
  localparam logic [2:0] P_D2   = 3'd3;
  localparam logic [2:0] P_D1   = 3'd4;
  localparam logic [2:0] P_D0   = 3'd5;
  localparam logic [2:0] P_CSUM = 3'd6;

  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  logic [1:0]      r_state_q, r_state_d;
  logic [BT_W-1:0] bit_tmr_q, bit_tmr_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_valid_q, byte_valid_d;
  logic            frame_err_q, frame_err_d;

  logic [2:0]      p_state_q, p_state_d;
  logic [7:0]      addr_q, addr_d;
  logic [31:0]     data_q, data_d;
  logic [7:0]      csum_q, csum_d;
  logic [TO_W-1:0] to_tmr_q, to_tmr_d;
  logic            cfg_update_q, cfg_update_d;
  logic            cmd_err_q, cmd_err_d;
  logic [1:0]      cfg_addr_q, cfg_addr_d;
  logic            mode_q, mode_d;
  logic [31:0]     trig_q, trig_d;
  logic [4:0]      cnum_q, cnum_d;
  logic [15:0]     cpsc_q, cpsc_d;

  always_comb begin
    r_state_d    = r_state_q;
    bit_tmr_d    = bit_tmr_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          r_state_d = R_START;
          bit_tmr_d = HALF_LOAD;
          bit_cnt_d = '0;
        end
      end
      R_START: begin
        if (bit_tmr_q == '0) begin
          bit_tmr_d = BIT_LOAD;
          r_state_d = rx_sync_q ? R_IDLE : R_DATA;
        end else begin
          bit_tmr_d = bit_tmr_q - 1'b1;
        end
      end
      R_DATA: begin
        if (bit_tmr_q == '0) begin
          bit_tmr_d = BIT_LOAD;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) r_state_d = R_STOP;
        end else begin
          bit_tmr_d = bit_tmr_q - 1'b1;
        end
      end
      R_STOP: begin
        // back to idle at mid-stop so a following start edge is caught at once
        if (bit_tmr_q == '0) begin
          r_state_d    = R_IDLE;
          byte_valid_d = rx_sync_q;
          frame_err_d  = !rx_sync_q;
        end else begin
          bit_tmr_d = bit_tmr_q - 1'b1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    p_state_d    = p_state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    csum_d       = csum_q;
    to_tmr_d     = to_tmr_q;
    cfg_update_d = 1'b0;
    cmd_err_d    = 1'b0;
    cfg_addr_d   = cfg_addr_q;
    mode_d       = mode_q;
    trig_d       = trig_q;
    cnum_d       = cnum_q;
    cpsc_d       = cpsc_q;
    if (frame_err_q) begin
      p_state_d = P_HUNT;
      cmd_err_d = 1'b1;
    end else if (byte_valid_q) begin
      to_tmr_d = TO_LOAD;
      case (p_state_q)
        P_HUNT: if (shift_q == 8'hA5) p_state_d = P_ADDR;
        P_ADDR: begin
          addr_d    = shift_q;
          csum_d    = shift_q;
          p_state_d = P_D3;
        end
        P_D3, P_D2, P_D1, P_D0: begin
          data_d    = {data_q[23:0], shift_q};
          csum_d    = csum_q ^ shift_q;
          p_state_d = p_state_q + 3'd1;
        end
        P_CSUM: begin
          p_state_d = P_HUNT;
          if (shift_q == csum_q && addr_q <= 8'd3) begin
            cfg_update_d = 1'b1;
            cfg_addr_d   = addr_q[1:0];
            case (addr_q[1:0])
              2'd0:    mode_d = data_q[0];
              2'd1:    trig_d = data_q;
              2'd2:    cnum_d = data_q[4:0];
              default: cpsc_d = data_q[15:0];
            endcase
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        default: p_state_d = P_HUNT;
      endcase
    end else if (p_state_q != P_HUNT) begin
      if (to_tmr_q == '0) begin
        p_state_d = P_HUNT;
        cmd_err_d = 1'b1;
      end else begin
        to_tmr_d = to_tmr_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      r_state_q    <= R_IDLE;
      bit_tmr_q    <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      p_state_q    <= P_HUNT;
      addr_q       <= '0;
      data_q       <= '0;
      csum_q       <= '0;
      to_tmr_q     <= TO_LOAD;
      cfg_update_q <= 1'b0;
      cmd_err_q    <= 1'b0;
      cfg_addr_q   <= '0;
      mode_q       <= RST_MODE;
      trig_q       <= RST_TRIG_PSC;
      cnum_q       <= RST_CHIRP_NUM;
      cpsc_q       <= RST_CHIRP_PSC;
    end else begin
      rx_meta_q    <= rs232_rx_i;
      rx_sync_q    <= rx_meta_q;
      rx_prev_q    <= rx_sync_q;
      r_state_q    <= r_state_d;
      bit_tmr_q    <= bit_tmr_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      p_state_q    <= p_state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      csum_q       <= csum_d;
      to_tmr_q     <= to_tmr_d;
      cfg_update_q <= cfg_update_d;
      cmd_err_q    <= cmd_err_d;
      cfg_addr_q   <= cfg_addr_d;
      mode_q       <= mode_d;
      trig_q       <= trig_d;
      cnum_q       <= cnum_d;
      cpsc_q       <= cpsc_d;
    end
  end

  assign mode_sel_o         = mode_q;
  assign trigger_freq_psc_o = trig_q;
  assign chirp_num_o        = cnum_q;
  assign chirp_freq_psc_o   = cpsc_q;
  assign cfg_update_o       = cfg_update_q;
  assign cfg_addr_o         = cfg_addr_q;
  assign cmd_err_o          = cmd_err_q;

endmodule
